string_frame_sequencer: RTL and testbench
=========================================

Name: string_frame_sequencer

Overview:
Sequences one full LED frame from a pixel memory into the WS2812B string driver. On a start request it reads NUM_PIXELS words from a synchronous-read frame buffer. It hands each word to the driver through its valid/ready handshake, then issues the blanking (latch) request and reports frame completion. It sits between the frame-buffer RAM and string_driver, one instance per string.

Parameters:
NUM_PIXELS, 150, pixels per frame; 1 <= NUM_PIXELS <= 2**ADDR_W
ADDR_W, 8, frame-buffer address width
COLOR_SWAP, 1, 1 = memory holds RGB and the block emits GRB (swap bits [23:16] and [15:8]); 0 = pass-through
READY_TIMEOUT, 4095, max cycles to wait for string_ready before forcing progress
HOLDOFF, 2, cycles string_ready is ignored after any pulse to the driver

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle request to send a frame; ignored while busy
auto_repeat  in  1  when high at frame end, the next frame starts immediately
mem_rd_en  out  1  frame-buffer read strobe
mem_addr  out  ADDR_W  frame-buffer read address
mem_rd_data  in  24  read data, valid exactly 1 cycle after mem_rd_en
pixel_data  out  24  to driver; colour-ordered per COLOR_SWAP
pixel_data_valid  out  1  to driver; one-cycle pulse per pixel
h_blank  out  1  to driver; one-cycle latch/reset request
string_ready  in  1  from driver
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse at end of frame
frame_count  out  16  completed frames, wraps at 0xFFFF -> 0
timeout_err  out  1  sticky; set when any ready wait times out; cleared by rst only

Behaviour:
- All outputs are registered. Reset values:
  - mem_rd_en, pixel_data_valid, h_blank, busy, frame_done, timeout_err = 0
  - mem_addr, pixel_data, frame_count = 0
  - state = IDLE, pixel index = 0
- Reset asserted in any state returns everything to these values the next cycle. No partial pulse may be emitted after reset.
- States and transitions:
  - IDLE: busy=0. frame_start=1 -> FETCH; index=0; busy<=1.
  - FETCH: mem_rd_en=1 for exactly one cycle, mem_addr=index -> CAPTURE.
  - CAPTURE: latch mem_rd_data, colour-reordered, into the pixel register -> WAIT_PIX.
  - WAIT_PIX: wait until string_ready=1 or the wait counter reaches READY_TIMEOUT.
    - On timeout, set timeout_err.
    - Either way: pixel_data<=pixel reg, pixel_data_valid<=1 (one cycle) -> HOLD_PIX.
  - HOLD_PIX: ignore string_ready for HOLDOFF cycles.
    - If index==NUM_PIXELS-1 -> BLANK.
    - Otherwise index+1 -> FETCH.
  - BLANK: h_blank<=1 for one cycle -> HOLD_BLK (HOLDOFF cycles) -> WAIT_BLK.
  - WAIT_BLK: string_ready=1 or timeout (sets timeout_err) -> DONE.
  - DONE: frame_done<=1 one cycle; frame_count+1.
    - If auto_repeat=1 sampled here -> FETCH with index=0, busy stays 1.
    - Otherwise -> IDLE, busy<=0 the same cycle frame_done rises.
- The wait counter clears on entry to every WAIT state. Timeout fires when the count equals READY_TIMEOUT.
- Per-pixel minimum latency with an always-ready driver is 4+HOLDOFF cycles.
- The first pixel after reset relies on the timeout path when the driver has not yet raised ready. Flagging this via timeout_err is required behaviour.
- frame_start while busy: ignored, not queued. frame_start in the same cycle as DONE with auto_repeat=0: ignored.
- pixel_data_valid and h_blank are never high in the same cycle.
- NUM_PIXELS=1: FETCH, CAPTURE, WAIT_PIX, HOLD_PIX, then straight to BLANK.
- Index counter is ADDR_W bits. The index never exceeds NUM_PIXELS-1, so no wrap occurs.

Decomposition:
- Shared package string_pkg:
  - state encoding constants
  - PIXEL_W=24
  - colour-order constants COLOR_RGB and COLOR_GRB
  - default HOLDOFF and default READY_TIMEOUT
- One sub-module, ready_waiter: holdoff counter plus ready/timeout counter.
  - Inputs: start, string_ready.
  - Outputs: go, timed_out.
  - Used for both pixel and blank waits.

Test Plan:
1. NUM_PIXELS=4, driver model ready 1 cycle after each holdoff; memory 0x112233, 0x445566, 0x778899, 0xAABBCC; frame_start -> four valid pulses with pixel_data 0x221133, 0x554466, 0x887799, 0xBBAACC; one h_blank; frame_done=1; frame_count=1; timeout_err=0.
2. COLOR_SWAP=0, same frame -> pixel_data equals memory words unchanged; mem_rd_en pulses exactly 4 times at addresses 0,1,2,3.
3. string_ready held 0, READY_TIMEOUT=16 -> each valid pulse issued 16 cycles after its WAIT_PIX entry; timeout_err=1 after the first pixel and stays 1 until rst.
4. auto_repeat=1 for 3 frames -> frame_done pulses 3 times; busy never drops between frames; frame_count=3; h_blank count=3.
5. rst asserted during pixel 2 -> next cycle all outputs at reset values, state IDLE. A subsequent frame_start sends pixel 0 first.
6. frame_start pulsed during HOLD_PIX and at DONE (auto_repeat=0) -> ignored; exactly one frame sent; busy=0 after frame_done.

Source files
------------

// File: rtl/string_pkg.sv
// Shared definitions for the LED string frame sequencer: FSM states, pixel
// width, colour-order selectors, default timing and the colour reorder helper.
// No ports; imported by string_frame_sequencer and ready_waiter.
package string_pkg;

  localparam int PIXEL_W = 24;

  // Colour order emitted on pixel_data. Memory always holds RGB.
  localparam bit COLOR_RGB = 1'b0;
  localparam bit COLOR_GRB = 1'b1;

  localparam int DEF_HOLDOFF       = 2;
  localparam int DEF_READY_TIMEOUT = 4095;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WAIT_PIX,
    ST_HOLD_PIX,
    ST_BLANK,
    ST_HOLD_BLK,
    ST_WAIT_BLK,
    ST_DONE
  } state_e;

  // GRB ordering swaps the red and green bytes; blue stays in the low byte.
  function automatic pixel_t color_order(input pixel_t rgb, input bit order);
    pixel_t res;
    res = rgb;
    if (order == COLOR_GRB) begin
      res = {rgb[15:8], rgb[23:16], rgb[7:0]};
    end else if (order == COLOR_RGB) begin
      res = rgb;
    end
    return res;
  endfunction

endpackage

// File: rtl/ready_waiter.sv
// Holdoff / ready-wait timer shared by the pixel and blanking phases of the sequencer.
// Latency: hold phase reports go after HOLDOFF+1 cycles; wait phase reports go on the
// first cycle string_ready is seen, or when the wait count reaches READY_TIMEOUT.
// Ports: clk/rst; start_i (restart, cycle before phase entry), hold_i (1 = holdoff
// phase, 0 = ready wait), string_ready_i; go_o (phase complete), timed_out_o.
module ready_waiter
  import string_pkg::*;
#(
  parameter int HOLDOFF       = DEF_HOLDOFF,
  parameter int READY_TIMEOUT = DEF_READY_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic hold_i,
  input  logic string_ready_i,
  output logic go_o,
  output logic timed_out_o
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int TW = (READY_TIMEOUT > 0) ? $clog2(READY_TIMEOUT + 1) : 1;

  logic          hold_mode_q, hold_mode_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          hold_done;
  logic          wait_done;

  // The pulse cycle itself counts as cycle 0 of the holdoff, so string_ready is
  // ignored for HOLDOFF further cycles after the pulse.
  assign hold_done = (hold_cnt_q == HW'(HOLDOFF));
  assign wait_done = (wait_cnt_q == TW'(READY_TIMEOUT));

  assign go_o        = hold_mode_q ? hold_done : (string_ready_i || wait_done);
  assign timed_out_o = !hold_mode_q && wait_done && !string_ready_i;

  always_comb begin
    hold_mode_d = hold_mode_q;
    hold_cnt_d  = hold_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (start_i) begin
      hold_mode_d = hold_i;
      hold_cnt_d  = '0;
      wait_cnt_d  = '0;
    end else if (hold_mode_q) begin
      if (!hold_done) hold_cnt_d = hold_cnt_q + HW'(1);
    end else begin
      // Saturate so an idle waiter never wraps back below the threshold.
      if (!wait_done) wait_cnt_d = wait_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_mode_q <= 1'b0;
      hold_cnt_q  <= '0;
      wait_cnt_q  <= '0;
    end else begin
      hold_mode_q <= hold_mode_d;
      hold_cnt_q  <= hold_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/string_frame_sequencer.sv
// Streams one frame of NUM_PIXELS words from a sync-read frame buffer into a WS2812B
// string driver, then requests blanking and reports completion.
// Latency: 4+HOLDOFF cycles per pixel with an always-ready driver; each ready wait is
// bounded by READY_TIMEOUT (sticky timeout_err). Backpressure: string_ready gates every
// pixel_data_valid / h_blank pulse. Ports: frame-buffer read (mem_*), driver (pixel_*,
// h_blank, string_ready), control (frame_start, auto_repeat) and status (busy,
// frame_done, frame_count, timeout_err). All outputs registered.
module string_frame_sequencer
  import string_pkg::*;
#(
  parameter int NUM_PIXELS    = 150,
  parameter int ADDR_W        = 8,
  parameter int COLOR_SWAP    = 1,
  parameter int READY_TIMEOUT = DEF_READY_TIMEOUT,
  parameter int HOLDOFF       = DEF_HOLDOFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               auto_repeat,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIXEL_W-1:0] mem_rd_data,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_data_valid,
  output logic               h_blank,
  input  logic               string_ready,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic               timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam bit ORDER = (COLOR_SWAP != 0) ? COLOR_GRB : COLOR_RGB;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  pixel_t              pix_reg_q, pix_reg_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  pixel_t              pixel_data_q, pixel_data_d;
  logic                valid_q, valid_d;
  logic                h_blank_q, h_blank_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                timeout_err_q, timeout_err_d;

  logic                wt_start;
  logic                wt_hold;
  logic                wt_go;
  logic                wt_timed_out;

  ready_waiter #(
    .HOLDOFF       (HOLDOFF),
    .READY_TIMEOUT (READY_TIMEOUT)
  ) u_waiter (
    .clk            (clk),
    .rst            (rst),
    .start_i        (wt_start),
    .hold_i         (wt_hold),
    .string_ready_i (string_ready),
    .go_o           (wt_go),
    .timed_out_o    (wt_timed_out)
  );

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    pix_reg_d     = pix_reg_q;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    pixel_data_d  = pixel_data_q;
    valid_d       = 1'b0;
    h_blank_d     = 1'b0;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;

    // mem_rd_en is raised on entry to FETCH so the read strobe coincides with the
    // FETCH cycle and the RAM data lands during CAPTURE.
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d     = ST_FETCH;
          index_d     = '0;
          busy_d      = 1'b1;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        pix_reg_d = color_order(mem_rd_data, ORDER);
        state_d   = ST_WAIT_PIX;
      end
      ST_WAIT_PIX: begin
        if (wt_go) begin
          if (wt_timed_out) timeout_err_d = 1'b1;
          pixel_data_d = pix_reg_q;
          valid_d      = 1'b1;
          state_d      = ST_HOLD_PIX;
        end
      end
      ST_HOLD_PIX: begin
        if (wt_go) begin
          if (index_q == LAST_IDX) begin
            state_d = ST_BLANK;
          end else begin
            index_d     = index_q + ADDR_W'(1);
            mem_rd_en_d = 1'b1;
            mem_addr_d  = index_q + ADDR_W'(1);
            state_d     = ST_FETCH;
          end
        end
      end
      ST_BLANK: begin
        h_blank_d = 1'b1;
        state_d   = ST_HOLD_BLK;
      end
      ST_HOLD_BLK: begin
        if (wt_go) state_d = ST_WAIT_BLK;
      end
      ST_WAIT_BLK: begin
        if (wt_go) begin
          if (wt_timed_out) timeout_err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        if (auto_repeat) begin
          state_d     = ST_FETCH;
          index_d     = '0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = '0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Restart the waiter on the edge that enters a hold or wait state, so its
    // counters read zero in the first cycle of that state.
    wt_hold  = (state_d == ST_HOLD_PIX) || (state_d == ST_HOLD_BLK);
    wt_start = (state_d != state_q) &&
               (wt_hold || (state_d == ST_WAIT_PIX) || (state_d == ST_WAIT_BLK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      pix_reg_q     <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      pixel_data_q  <= '0;
      valid_q       <= 1'b0;
      h_blank_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      pix_reg_q     <= pix_reg_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      pixel_data_q  <= pixel_data_d;
      valid_q       <= valid_d;
      h_blank_q     <= h_blank_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_rd_en        = mem_rd_en_q;
  assign mem_addr         = mem_addr_q;
  assign pixel_data       = pixel_data_q;
  assign pixel_data_valid = valid_q;
  assign h_blank          = h_blank_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_string_frame_sequencer.sv
// Directed bench: a GRB instance and a pass-through instance driven in lockstep
// from a 4-word frame buffer, with a small string-driver ready model.
// Expected pixel timing: FETCH, CAPTURE, WAIT (1 or TO+1 cycles), HOLD (HO+1 cycles).
module tb_string_frame_sequencer;

  localparam int NP = 4;
  localparam int AW = 8;
  localparam int HO = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst, frame_start, auto_repeat, string_ready;

  logic          a_rd_en, b_rd_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [23:0]   a_rd_data, b_rd_data;
  logic [23:0]   a_pix, b_pix;
  logic          a_vld, b_vld, a_blk, b_blk, a_busy, b_busy, a_done, b_done;
  logic [15:0]   a_cnt, b_cnt;
  logic          a_err, b_err;

  logic [23:0] mem     [0:3] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
  logic [23:0] exp_grb [0:3] = '{24'h221133, 24'h554466, 24'h887799, 24'hBBAACC};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem[a_addr[1:0]];
    if (b_rd_en) b_rd_data <= mem[b_addr[1:0]];
  end

  string_frame_sequencer #(.NUM_PIXELS(NP), .ADDR_W(AW), .COLOR_SWAP(1),
                           .READY_TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .auto_repeat(auto_repeat),
    .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rd_data(a_rd_data),
    .pixel_data(a_pix), .pixel_data_valid(a_vld), .h_blank(a_blk),
    .string_ready(string_ready), .busy(a_busy), .frame_done(a_done),
    .frame_count(a_cnt), .timeout_err(a_err));

  string_frame_sequencer #(.NUM_PIXELS(NP), .ADDR_W(AW), .COLOR_SWAP(0),
                           .READY_TIMEOUT(TO), .HOLDOFF(HO)) dut_ns (
    .clk(clk), .rst(rst), .frame_start(frame_start), .auto_repeat(auto_repeat),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
    .pixel_data(b_pix), .pixel_data_valid(b_vld), .h_blank(b_blk),
    .string_ready(string_ready), .busy(b_busy), .frame_done(b_done),
    .frame_count(b_cnt), .timeout_err(b_err));

  int n_vec = 0;
  int n_bad = 0;

  int cyc, n_vld, n_blk, n_done, n_rd, blk_cyc, done_cyc, busy_drop, overlap, desync;
  int vc [0:15];
  logic [23:0] pa [0:15];
  logic [23:0] pb [0:15];
  logic [AW-1:0] ra [0:15];
  logic err_first, busy_at_done;
  int drv_mode, rcnt;
  bit inj;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_busy"},   a_busy,  1'b0);
    chk({pfx, "_rd_en"},  a_rd_en, 1'b0);
    chk({pfx, "_addr"},   a_addr,  '0);
    chk({pfx, "_vld"},    a_vld,   1'b0);
    chk({pfx, "_blank"},  a_blk,   1'b0);
    chk({pfx, "_done"},   a_done,  1'b0);
    chk({pfx, "_pix"},    a_pix,   24'h0);
    chk({pfx, "_count"},  a_cnt,   16'h0);
    chk({pfx, "_err"},    a_err,   1'b0);
  endtask

  // Runs until nframes frame_done pulses (or the budget expires), logging every
  // driver-side event. frame_start must already be set by the caller.
  task automatic run_frames(input int nframes, input int budget);
    cyc = 0; n_vld = 0; n_blk = 0; n_done = 0; n_rd = 0; blk_cyc = -100;
    done_cyc = 0; busy_drop = 0; overlap = 0; desync = 0;
    err_first = 1'bx; busy_at_done = 1'bx; rcnt = 0;
    for (int i = 0; i < budget && n_done < nframes; i++) begin
      @(negedge clk);
      cyc++;
      frame_start = 1'b0;
      if (a_vld) begin
        if (n_vld < 16) begin
          pa[n_vld] = a_pix; pb[n_vld] = b_pix; vc[n_vld] = cyc;
        end
        if (n_vld == 0) err_first = a_err;
        n_vld++;
        if (inj) frame_start = 1'b1;
      end
      if (a_blk) begin n_blk++; blk_cyc = cyc; end
      if (a_vld && a_blk) overlap++;
      if (a_vld !== b_vld || a_blk !== b_blk || a_done !== b_done || a_busy !== b_busy) desync++;
      if (a_rd_en) begin
        if (n_rd < 16) ra[n_rd] = a_addr;
        n_rd++;
      end
      if (a_done) begin
        n_done++; done_cyc = cyc; busy_at_done = a_busy;
      end else if (!a_busy) begin
        busy_drop++;
      end
      if (n_done >= nframes - 1) auto_repeat = 1'b0;
      if (inj && cyc == blk_cyc + 4) frame_start = 1'b1;
      case (drv_mode)
        0: string_ready = 1'b1;
        1: begin
          if (a_vld || a_blk) rcnt = HO + 2;
          if (rcnt > 0) begin rcnt--; string_ready = 1'b0; end
          else string_ready = 1'b1;
        end
        default: string_ready = 1'b0;
      endcase
    end
    chk("frames_done", n_done, nframes);
  endtask

  initial begin
    int seen;
    int extra;
    rst = 1'b1; frame_start = 1'b0; auto_repeat = 1'b0; string_ready = 1'b1;
    drv_mode = 0; rcnt = 0; inj = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);

    // Nominal frame, driver ready one cycle after each holdoff; both colour orders.
    drv_mode = 1; frame_start = 1'b1;
    run_frames(1, 300);
    chk("t1_vld_cnt", n_vld, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_grb%0d", i), pa[i], exp_grb[i]);
      chk($sformatf("t2_rgb%0d", i), pb[i], mem[i]);
      chk($sformatf("t2_addr%0d", i), ra[i], i);
    end
    chk("t2_rd_cnt", n_rd, 4);
    chk("t1_blank_cnt", n_blk, 1);
    chk("t1_count", a_cnt, 16'd1);
    chk("t1_err", a_err, 1'b0);
    chk("t1_err_first", err_first, 1'b0);
    chk("t1_overlap", overlap, 0);
    chk("t1_lockstep", desync, 0);
    chk("t1_busy_at_done", busy_at_done, 1'b0);

    // Always-ready driver with frame_start pulses during HOLD_PIX and DONE.
    drv_mode = 0; inj = 1'b1; frame_start = 1'b1;
    run_frames(1, 300);
    inj = 1'b0;
    chk("t6_vld_cnt", n_vld, 4);
    chk("t6_first_lat", vc[0], 4);
    chk("t6_pix_gap", vc[1] - vc[0], 4 + HO);
    chk("t6_done_after_blank", done_cyc - blk_cyc, 5);
    chk("t6_count", a_cnt, 16'd2);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_vld || a_busy || a_rd_en) extra++;
    end
    chk("t6_ignored_start", extra, 0);

    // Driver never ready: every wait runs to the timeout.
    drv_mode = 2; string_ready = 1'b0; frame_start = 1'b1;
    run_frames(1, 400);
    chk("t3_vld_cnt", n_vld, 4);
    chk("t3_first_lat", vc[0], 2 + TO + 2);
    chk("t3_pix_gap", vc[1] - vc[0], 2 + (TO + 1) + (HO + 1));
    chk("t3_err_first", err_first, 1'b1);
    chk("t3_err_ns", b_err, 1'b1);
    repeat (5) @(negedge clk);
    chk("t3_err_sticky", a_err, 1'b1);

    // Reset in the middle of the frame, during the fetch of pixel 2.
    drv_mode = 0; string_ready = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge clk);
      if (a_vld) seen++;
    end
    repeat (3) @(negedge clk);
    chk("t5_mid_fetch", {a_rd_en, a_addr}, {1'b1, 8'd2});
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("t5");
    rst = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    run_frames(1, 300);
    chk("t5_first_addr", ra[0], 0);
    chk("t5_first_pix", pa[0], exp_grb[0]);
    chk("t5_first_lat", vc[0], 4);
    chk("t5_count", a_cnt, 16'd1);

    // Three back-to-back frames via auto_repeat.
    auto_repeat = 1'b1; frame_start = 1'b1;
    run_frames(3, 600);
    chk("t4_blank_cnt", n_blk, 3);
    chk("t4_vld_cnt", n_vld, 12);
    chk("t4_busy_drop", busy_drop, 0);
    chk("t4_count", a_cnt, 16'd4);
    chk("t4_count_ns", b_cnt, 16'd4);
    chk("t4_f3_pix0", pa[8], exp_grb[0]);
    chk("t4_overlap", overlap, 0);
    chk("t4_busy_at_done", busy_at_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
